hazard_ctrl: RTL and testbench

- Interlock and sequencing controller for the decode stage.
- Tracks in-flight load targets in a shift-register scoreboard and raises a combinational `stall` when the decode-stage instruction reads a pending load target.
- Sequences a multi-cycle `flush` after a taken branch, latches `halt`, and counts stall cycles.
- Sits beside decode and drives decode's `stall`, `flush` and `halt` inputs.

---
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage load-use interlock, branch flush sequencer and halt latch
module hazard_ctrl #(
    parameter int LOAD_LAT     = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_valid,
    input  logic [4:0]  d_s_1,
    input  logic [4:0]  d_s_2,
    input  logic        d_is_load,
    input  logic [4:0]  d_tgt,
    input  logic        br_taken,
    input  logic        halt_in,
    output logic        stall,
    output logic        flush,
    output logic        halt,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_HALTED
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       flush_nxt, halt_nxt;
    logic [4:0] sb [LOAD_LAT];
    logic       hit;
    logic       sb_push;

    // Does either live decode source match a pending load target (r0 never matches)
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (sb[i] != 5'd0 &&
                ((d_s_1 != 5'd0 && d_s_1 == sb[i]) ||
                 (d_s_2 != 5'd0 && d_s_2 == sb[i])))
                hit = 1'b1;
        end
    end

    // A squashed, halted or reset-cycle instruction never stalls
    assign stall   = !rst && d_valid && !flush && !halt && hit;
    // Only a load that actually leaves decode this cycle enters the scoreboard
    assign sb_push = d_valid && d_is_load && !stall && !flush && (d_tgt != 5'd0);

    // Next-state logic: halt beats branch, a branch during flush restarts the count
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flush_nxt = flush;
        halt_nxt  = halt;
        if (state != S_HALTED && halt_in) begin
            state_nxt = S_HALTED;
            halt_nxt  = 1'b1;
            flush_nxt = 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (br_taken) begin
                        state_nxt = S_FLUSH;
                        flush_nxt = 1'b1;
                        cnt_nxt   = CNT_INIT;
                    end
                end
                S_FLUSH: begin
                    if (br_taken) begin
                        flush_nxt = 1'b1;
                        cnt_nxt   = CNT_INIT;
                    end else if (cnt != 3'd0) begin
                        cnt_nxt   = cnt - 3'd1;
                    end else begin
                        state_nxt = S_RUN;
                        flush_nxt = 1'b0;
                    end
                end
                S_HALTED: begin
                end
                default: begin
                    state_nxt = S_RUN;
                    flush_nxt = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= 3'd0;
            flush <= 1'b0;
            halt  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            flush <= flush_nxt;
            halt  <= halt_nxt;
        end
    end

    // Scoreboard shift and stall counter, both frozen once halted
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LOAD_LAT; i++)
                sb[i] <= 5'd0;
            stall_cycles <= 32'd0;
        end else if (state != S_HALTED) begin
            sb[0] <= sb_push ? d_tgt : 5'd0;
            for (int i = 1; i < LOAD_LAT; i++)
                sb[i] <= sb[i-1];
            if (stall && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int LL = 2;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst, d_valid, d_is_load, br_taken, halt_in;
    logic [4:0]  d_s_1, d_s_2, d_tgt;
    logic        stall, flush, halt;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl #(.LOAD_LAT(LL), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_s_1(d_s_1), .d_s_2(d_s_2),
        .d_is_load(d_is_load), .d_tgt(d_tgt), .br_taken(br_taken), .halt_in(halt_in),
        .stall(stall), .flush(flush), .halt(halt), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each register remembers the last cycle it is still pending,
    // the flush window remembers its last cycle, halt is a sticky flag.
    int          cyc = 0;
    int          busy_until [32];
    int          flush_end = -100;
    bit          m_halted = 1'b0;
    bit          model_on = 1'b0;
    longint      m_count = 0;

    function automatic bit m_flush();
        return !m_halted && (cyc <= flush_end);
    endfunction

    function automatic bit m_pending(input logic [4:0] r);
        return (r != 5'd0) && (busy_until[r] >= cyc);
    endfunction

    function automatic bit m_stall();
        return !rst && d_valid && !m_flush() && !m_halted &&
               (m_pending(d_s_1) || m_pending(d_s_2));
    endfunction

    initial for (int r = 0; r < 32; r++) busy_until[r] = -100;

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) busy_until[r] = -100;
            flush_end = -100;
            m_halted  = 1'b0;
            m_count   = 0;
            model_on  = 1'b1;
        end else if (!m_halted) begin
            if (m_stall() && m_count < 64'hFFFF_FFFF) m_count++;
            if (d_valid && d_is_load && !m_stall() && !m_flush() && d_tgt != 5'd0)
                busy_until[d_tgt] = cyc + LL;
            if (halt_in) m_halted = 1'b1;
            else if (br_taken) flush_end = cyc + FC;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_stall", {31'd0, stall}, {31'd0, m_stall()});
            chk("model_flush", {31'd0, flush}, {31'd0, m_flush()});
            chk("model_halt", {31'd0, halt}, {31'd0, m_halted});
            chk("model_stall_cycles", stall_cycles, m_count[31:0]);
        end
    end

    task automatic set(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic ld, input logic [4:0] tgt,
                       input logic br, input logic hl, input logic r);
        d_valid = v; d_s_1 = s1; d_s_2 = s2; d_is_load = ld; d_tgt = tgt;
        br_taken = br; halt_in = hl; rst = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bubble();
        set(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        set(0, 0, 0, 0, 0, 0, 0, 1);
        tick(); tick();

        // reset state
        bubble();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_count", stall_cycles, 32'd0);
        tick();

        // immediate dependency: load r5 then reader of r5 held two cycles
        set(1, 0, 0, 1, 5, 0, 0, 0); tick();
        set(1, 5, 0, 0, 0, 0, 0, 0); chk("dep_stall0", {31'd0, stall}, 32'd1); tick();
        set(1, 5, 0, 0, 0, 0, 0, 0); chk("dep_stall1", {31'd0, stall}, 32'd1); tick();
        set(1, 5, 0, 0, 0, 0, 0, 0); chk("dep_go", {31'd0, stall}, 32'd0); tick();
        bubble(); chk("dep_count", stall_cycles, 32'd2); tick();

        // no false stalls: r0 target/sources, and an unrelated source
        set(1, 0, 0, 1, 0, 0, 0, 0); tick();
        set(1, 0, 0, 0, 0, 0, 0, 0); chk("r0_nostall", {31'd0, stall}, 32'd0); tick();
        set(1, 0, 0, 1, 7, 0, 0, 0); tick();
        set(1, 0, 8, 0, 0, 0, 0, 0); chk("r8_nostall", {31'd0, stall}, 32'd0); tick();
        bubble(); tick();

        // both sources equal to the target: same two-cycle stall
        set(1, 0, 0, 1, 9, 0, 0, 0); tick();
        set(1, 9, 9, 0, 0, 0, 0, 0); chk("dual_stall", {31'd0, stall}, 32'd1); tick();
        set(1, 9, 9, 0, 0, 0, 0, 0); tick();
        set(1, 9, 9, 0, 0, 0, 0, 0); chk("dual_go", {31'd0, stall}, 32'd0); tick();
        bubble(); chk("dual_count", stall_cycles, 32'd4); tick();

        // dependent trailing by two instructions: one stall cycle
        set(1, 0, 0, 1, 10, 0, 0, 0); tick();
        set(1, 3, 0, 0, 0, 0, 0, 0); tick();
        set(1, 10, 0, 0, 0, 0, 0, 0); chk("trail_stall", {31'd0, stall}, 32'd1); tick();
        set(1, 10, 0, 0, 0, 0, 0, 0); chk("trail_go", {31'd0, stall}, 32'd0); tick();
        bubble(); chk("trail_count", stall_cycles, 32'd5); tick();

        // single branch: flush two cycles, squashed load never enters scoreboard
        set(0, 0, 0, 0, 0, 1, 0, 0); tick();
        set(1, 0, 0, 1, 12, 0, 0, 0); chk("fl_on0", {31'd0, flush}, 32'd1); tick();
        set(1, 12, 0, 0, 0, 0, 0, 0); chk("fl_on1", {31'd0, flush}, 32'd1);
        chk("fl_nostall", {31'd0, stall}, 32'd0); tick();
        set(1, 12, 0, 0, 0, 0, 0, 0); chk("fl_off", {31'd0, flush}, 32'd0);
        chk("fl_noentry", {31'd0, stall}, 32'd0); tick();
        bubble(); tick();

        // back-to-back branches: flush three cycles
        set(0, 0, 0, 0, 0, 1, 0, 0); tick();
        set(0, 0, 0, 0, 0, 1, 0, 0); chk("bb_on0", {31'd0, flush}, 32'd1); tick();
        bubble(); chk("bb_on1", {31'd0, flush}, 32'd1); tick();
        bubble(); chk("bb_on2", {31'd0, flush}, 32'd1); tick();
        bubble(); chk("bb_off", {31'd0, flush}, 32'd0); tick();

        // halt beats branch; everything frozen afterwards
        set(1, 0, 0, 1, 13, 0, 0, 0); tick();
        set(1, 13, 0, 0, 0, 1, 1, 0); chk("h_prestall", {31'd0, stall}, 32'd1); tick();
        set(1, 13, 0, 0, 0, 1, 0, 0);
        chk("h_halt", {31'd0, halt}, 32'd1);
        chk("h_flush", {31'd0, flush}, 32'd0);
        chk("h_stall", {31'd0, stall}, 32'd0);
        chk("h_count", stall_cycles, 32'd6); tick();
        set(1, 13, 13, 1, 14, 1, 0, 0);
        chk("h_sticky", {31'd0, halt}, 32'd1);
        chk("h_frozen", stall_cycles, 32'd6); tick();
        set(0, 0, 0, 0, 0, 0, 0, 1); tick();
        bubble();
        chk("hr_halt", {31'd0, halt}, 32'd0);
        chk("hr_flush", {31'd0, flush}, 32'd0);
        chk("hr_count", stall_cycles, 32'd0); tick();

        // reset while a dependent waits clears the scoreboard
        set(1, 0, 0, 1, 5, 0, 0, 0); tick();
        set(1, 5, 0, 0, 0, 0, 0, 1); chk("mr_rst_stall", {31'd0, stall}, 32'd0); tick();
        set(1, 5, 0, 0, 0, 0, 0, 0); chk("mr_cleared", {31'd0, stall}, 32'd0);
        chk("mr_count", stall_cycles, 32'd0); tick();
        bubble(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
